// File: rtl/eth_phy_mgmt_if.sv
// Host command/response port of the PHY management controller.
// Host drives requests; the controller answers with one response pulse.
interface eth_phy_mgmt_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [4:0]  cmd_reg;
  logic [15:0] cmd_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;

  modport master (
    output cmd_valid, cmd_write, cmd_reg, cmd_wdata,
    input  cmd_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_reg, cmd_wdata,
    output cmd_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/eth_phy_mgmt.sv
// PHY bring-up and MDIO management: hard reset, init write,
// periodic BMSR link poll and host register access.
module eth_phy_mgmt #(
  parameter int          MDC_DIV     = 25,
  parameter int          RST_CYCLES  = 1_250_000,
  parameter int          WAIT_CYCLES = 6_250_000,
  parameter int          POLL_CYCLES = 12_500_000,
  parameter logic [4:0]  PHY_ADDR    = 5'd0,
  parameter logic [4:0]  INIT_REG    = 5'd0,
  parameter logic [15:0] INIT_DATA   = 16'h1140
) (
  input  logic clk,
  input  logic rst_n,
  output logic phy_rst_n,
  output logic mdc,
  output logic mdio_o,
  output logic mdio_oe,
  input  logic mdio_i,
  output logic init_done,
  output logic link_up,
  eth_phy_mgmt_if.slave host
);

  typedef enum logic [2:0] {
    HOLD, WAIT, INIT, IDLE, POLL, HOST
  } state_t;

  state_t      state;
  logic [31:0] cnt;
  logic [31:0] ptmr;
  logic [15:0] dcnt;
  logic [5:0]  bidx;
  logic [62:0] sreg;
  logic        busy;
  logic        frd;
  logic        fdone;
  logic        pend;
  logic        hwr;
  logic        ready;
  logic        rvld;
  logic [15:0] rdata;
  logic [15:0] rsp;

  logic        go;
  logic        go_rd;
  logic [4:0]  go_reg;
  logic [15:0] go_dat;
  logic [63:0] fw;
  logic        hs;
  logic        expire;

  assign hs     = host.cmd_valid & ready;
  assign expire = (ptmr == 32'd1);

  assign host.cmd_ready = ready;
  assign host.rsp_valid = rvld;
  assign host.rsp_rdata = rsp;

  // Read frames carry ones in TA/DATA so the line idles high
  function automatic logic [63:0] frame(
    input logic        rd,
    input logic [4:0]  r,
    input logic [15:0] d
  );
    if (rd)
      frame = {32'hFFFF_FFFF, 2'b01, 2'b10,
               PHY_ADDR, r, 18'h3_FFFF};
    else
      frame = {32'hFFFF_FFFF, 2'b01, 2'b01,
               PHY_ADDR, r, 2'b10, d};
  endfunction

  // Pick the frame to launch this cycle; host wins over a poll
  always_comb begin
    go     = 1'b0;
    go_rd  = 1'b0;
    go_reg = INIT_REG;
    go_dat = INIT_DATA;
    unique case (1'b1)
      (state == WAIT) &&
      (cnt == 32'(WAIT_CYCLES - 1)): go = 1'b1;
      (state == IDLE) && hs: begin
        go     = 1'b1;
        go_rd  = ~host.cmd_write;
        go_reg = host.cmd_reg;
        go_dat = host.cmd_wdata;
      end
      (state == IDLE) && !hs && (expire || pend): begin
        go     = 1'b1;
        go_rd  = 1'b1;
        go_reg = 5'd1;
        go_dat = 16'h0000;
      end
      default: ;
    endcase
    fw = frame(go_rd, go_reg, go_dat);
  end

  // Sequencer, poll timer and MDC/MDIO bit engine
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= HOLD;
      cnt       <= '0;
      ptmr      <= '0;
      dcnt      <= '0;
      bidx      <= '0;
      sreg      <= '0;
      busy      <= 1'b0;
      frd       <= 1'b0;
      fdone     <= 1'b0;
      pend      <= 1'b0;
      hwr       <= 1'b0;
      ready     <= 1'b0;
      rvld      <= 1'b0;
      rdata     <= '0;
      rsp       <= '0;
      phy_rst_n <= 1'b0;
      mdc       <= 1'b0;
      mdio_o    <= 1'b1;
      mdio_oe   <= 1'b0;
      init_done <= 1'b0;
      link_up   <= 1'b0;
    end else begin
      fdone <= 1'b0;
      rvld  <= 1'b0;
      if (ptmr != 32'd0) ptmr <= ptmr - 32'd1;
      if (expire) pend <= 1'b1;

      if (go) begin
        sreg    <= fw[62:0];
        mdio_o  <= fw[63];
        mdio_oe <= 1'b1;
        mdc     <= 1'b0;
        dcnt    <= '0;
        bidx    <= 6'd63;
        busy    <= 1'b1;
        frd     <= go_rd;
      end else if (busy) begin
        if (dcnt == 16'(MDC_DIV - 1)) begin
          dcnt <= '0;
          if (!mdc) begin
            mdc   <= 1'b1;
            rdata <= {rdata[14:0], mdio_i};
          end else begin
            mdc <= 1'b0;
            if (bidx == 6'd0) begin
              busy    <= 1'b0;
              mdio_oe <= 1'b0;
              mdio_o  <= 1'b1;
              fdone   <= 1'b1;
              if (state != HOST)
                ptmr <= 32'(POLL_CYCLES);
            end else begin
              sreg    <= {sreg[61:0], 1'b0};
              mdio_o  <= sreg[62];
              mdio_oe <= ~(frd && (bidx <= 6'd18));
              bidx    <= bidx - 6'd1;
            end
          end
        end else begin
          dcnt <= dcnt + 16'd1;
        end
      end

      unique case (state)
        HOLD: begin
          if (cnt == 32'(RST_CYCLES - 1)) begin
            cnt       <= '0;
            phy_rst_n <= 1'b1;
            state     <= WAIT;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        WAIT: begin
          if (go) begin
            cnt   <= '0;
            state <= INIT;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        INIT: begin
          if (fdone) begin
            init_done <= 1'b1;
            ready     <= 1'b1;
            state     <= IDLE;
          end
        end
        IDLE: begin
          if (go) begin
            ready <= 1'b0;
            if (hs) begin
              hwr   <= host.cmd_write;
              state <= HOST;
            end else begin
              pend  <= 1'b0;
              state <= POLL;
            end
          end
        end
        POLL: begin
          if (fdone) begin
            link_up <= rdata[2];
            ready   <= 1'b1;
            state   <= IDLE;
          end
        end
        HOST: begin
          if (fdone) begin
            rvld  <= 1'b1;
            rsp   <= hwr ? 16'h0000 : rdata;
            ready <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= HOLD;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_phy_mgmt.sv
// Directed bench for eth_phy_mgmt with small timing parameters.
// Frames are captured bit by bit while a PHY model drives mdio_i.
module tb_eth_phy_mgmt;

  localparam logic [63:0] INIT_F = 64'hFFFF_FFFF_5002_1140;
  localparam logic [63:0] POLL_F = 64'hFFFF_FFFF_6007_FFFF;
  localparam logic [63:0] RD2_F  = 64'hFFFF_FFFF_600B_FFFF;
  localparam logic [63:0] RD3_F  = 64'hFFFF_FFFF_600F_FFFF;
  localparam logic [63:0] WR4_F  = 64'hFFFF_FFFF_5012_01E1;
  localparam logic [63:0] OE_WR  = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] OE_RD  = 64'hFFFF_FFFF_FFFC_0000;

  logic clk = 1'b0;
  logic rst_n;
  logic phy_rst_n;
  logic mdc;
  logic mdio_o;
  logic mdio_oe;
  logic mdio_i;
  logic init_done;
  logic link_up;

  eth_phy_mgmt_if bus ();

  eth_phy_mgmt #(
    .MDC_DIV    (2),
    .RST_CYCLES (10),
    .WAIT_CYCLES(20),
    .POLL_CYCLES(300),
    .PHY_ADDR   (5'd0),
    .INIT_REG   (5'd0),
    .INIT_DATA  (16'h1140)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .phy_rst_n(phy_rst_n),
    .mdc      (mdc),
    .mdio_o   (mdio_o),
    .mdio_oe  (mdio_oe),
    .mdio_i   (mdio_i),
    .init_done(init_done),
    .link_up  (link_up),
    .host     (bus)
  );

  always #4 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;
  int c0 = 0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic step_to(input int t);
    while (cyc - c0 < t) step(1);
  endtask

  task automatic wait_oe(input int lim, output int t);
    while (mdio_oe !== 1'b1 && cyc - c0 < lim) step(1);
    t = cyc - c0;
  endtask

  // Called #1 after the frame start edge; returns 128*2 cycles later
  task automatic capture(input logic [15:0] rv,
                         output logic [63:0] bits,
                         output logic [63:0] oes,
                         output logic bad);
    bad = 1'b0;
    for (int k = 0; k < 64; k++) begin
      int i;
      i = 63 - k;
      mdio_i  = (i <= 15) ? rv[4'(i)] : 1'b1;
      bits[i] = mdio_o;
      oes[i]  = mdio_oe;
      if (mdc !== 1'b0 || bus.cmd_ready !== 1'b0) bad = 1'b1;
      step(2);
      if (mdc !== 1'b1 || mdio_oe !== oes[i]) bad = 1'b1;
      step(1);
      if (mdc !== 1'b1 || mdio_oe !== oes[i]) bad = 1'b1;
      step(1);
    end
  endtask

  task automatic bringup();
    int t;
    logic [63:0] b;
    logic [63:0] o;
    logic bad;
    @(negedge clk);
    rst_n = 1'b1;
    c0 = cyc;
    t = 0;
    while (phy_rst_n !== 1'b1 && t < 100) begin
      step(1);
      t = cyc - c0;
    end
    chk("phy_rst_rise", 64'(t), 64'd10);
    wait_oe(200, t);
    chk("first_frame", 64'(t), 64'd30);
    capture(16'h0000, b, o, bad);
    chk("init_bits", b, INIT_F);
    chk("init_oe", o, OE_WR);
    chk("init_timing", 64'(bad), 64'd0);
    chk("init_end", 64'({mdc, mdio_oe, init_done}), 64'd0);
    chk("init_len", 64'(cyc - c0), 64'd286);
    step(1);
    chk("init_done", 64'({init_done, bus.cmd_ready}), 64'b11);
  endtask

  initial begin
    int t;
    logic [63:0] b;
    logic [63:0] o;
    logic bad;
    rst_n         = 1'b1;
    mdio_i        = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_reg   = 5'd0;
    bus.cmd_wdata = 16'h0000;
    #1 rst_n = 1'b0;
    step(3);
    chk("rst_pins", 64'({phy_rst_n, mdc, mdio_o, mdio_oe}), 64'b0010);
    chk("rst_status", 64'({init_done, link_up, bus.cmd_ready,
                          bus.rsp_valid}), 64'd0);
    chk("rst_rdata", 64'(bus.rsp_rdata), 64'd0);

    bringup();

    wait_oe(700, t);
    chk("poll1_start", 64'(t), 64'd586);
    capture(16'h7869, b, o, bad);
    chk("poll1_bits", b, POLL_F);
    chk("poll1_oe", o, OE_RD);
    chk("poll1_timing", 64'(bad), 64'd0);
    step(1);
    chk("link_down", 64'(link_up), 64'd0);

    wait_oe(1200, t);
    chk("poll2_start", 64'(t), 64'd1142);
    capture(16'h786D, b, o, bad);
    chk("poll2_bits", b, POLL_F);
    step(1);
    chk("link_up", 64'(link_up), 64'd1);

    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_reg   = 5'd2;
    wait_oe(1500, t);
    bus.cmd_valid = 1'b0;
    chk("hrd_start", 64'(t), 64'd1400);
    capture(16'h0022, b, o, bad);
    chk("hrd_bits", b, RD2_F);
    chk("hrd_oe", o, OE_RD);
    chk("hrd_timing", 64'(bad), 64'd0);
    chk("hrd_end_rsp", 64'(bus.rsp_valid), 64'd0);
    step(1);
    chk("hrd_rsp", 64'({bus.rsp_valid, bus.cmd_ready, bus.rsp_rdata}),
        64'({2'b11, 16'h0022}));
    step(1);
    chk("hrd_pulse", 64'({bus.rsp_valid, bus.rsp_rdata}),
        64'({1'b0, 16'h0022}));

    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_reg   = 5'd4;
    bus.cmd_wdata = 16'h01E1;
    wait_oe(1800, t);
    bus.cmd_valid = 1'b0;
    chk("hwr_start", 64'(t), 64'd1659);
    capture(16'h0000, b, o, bad);
    chk("hwr_bits", b, WR4_F);
    chk("hwr_oe", o, OE_WR);
    step(1);
    chk("hwr_rsp", 64'({bus.rsp_valid, bus.rsp_rdata}),
        64'({1'b1, 16'h0000}));

    wait_oe(2000, t);
    chk("pend_poll_start", 64'(t), 64'd1917);
    capture(16'h786D, b, o, bad);
    chk("pend_poll_bits", b, POLL_F);
    step(1);
    chk("pend_link", 64'(link_up), 64'd1);

    step_to(2472);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_reg   = 5'd3;
    step(1);
    bus.cmd_valid = 1'b0;
    chk("tie_start", 64'({mdio_oe, bus.cmd_ready}), 64'b10);
    capture(16'hABCD, b, o, bad);
    chk("tie_host_bits", b, RD3_F);
    step(1);
    chk("tie_rsp", 64'({bus.rsp_valid, bus.rsp_rdata}),
        64'({1'b1, 16'hABCD}));
    step(1);
    chk("tie_poll", 64'({mdio_oe, 32'(cyc - c0)}),
        64'({1'b1, 32'd2731}));

    step(94);
    chk("pre_rst", 64'({mdc, mdio_oe, mdio_o}), 64'b111);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_pins", 64'({phy_rst_n, mdc, mdio_o, mdio_oe}), 64'b0010);
    chk("mid_rst_status", 64'({init_done, link_up, bus.cmd_ready,
                              bus.rsp_valid}), 64'd0);
    chk("mid_rst_rdata", 64'(bus.rsp_rdata), 64'd0);
    step(3);

    bringup();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/eth_phy_mgmt.md
# eth_phy_mgmt

PHY bring-up and management controller for the RGMII Ethernet path. Sits beside the Ethernet core on the 125 MHz `clk` domain. It owns the PHY hard reset and the MDC/MDIO pins. Its job:
- reset the PHY and wait for it to settle;
- perform one configuration register write;
- poll link status periodically;
- serve register read/write requests from a host command port.

## Interface
Parameters:
- `MDC_DIV`, 25: `clk` cycles per MDC half-period (MDC period = 2*MDC_DIV cycles; 2.5 MHz at 125 MHz).
- `RST_CYCLES`, 1_250_000: cycles `phy_rst_n` is held low after reset (10 ms).
- `WAIT_CYCLES`, 6_250_000: cycles waited after `phy_rst_n` rises, before first MDIO frame (50 ms).
- `POLL_CYCLES`, 12_500_000: interval between link-status polls (100 ms).
- `PHY_ADDR`, 5'd0: PHY address placed in every frame.
- `INIT_REG`, 5'd0 and `INIT_DATA`, 16'h1140: register and value of the single init write.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: system clock, 125 MHz.
- `rst_n` in 1: asynchronous active-low reset.
- `phy_rst_n` out 1: PHY hard reset, active low.
- `mdc` out 1: management clock.
- `mdio_o` out 1: MDIO output data (top level builds tristate).
- `mdio_oe` out 1: MDIO output enable.
- `mdio_i` in 1: MDIO input data.
- `init_done` out 1: high once the init write has completed; stays high.
- `link_up` out 1: BMSR (reg 1) bit 2 from the most recent poll.
- `cmd_valid` in 1: host request valid.
- `cmd_ready` out 1: host request accepted when both `cmd_valid` and `cmd_ready` are high.
- `cmd_write` in 1: 1 = write, 0 = read.
- `cmd_reg` in 5: register address.
- `cmd_wdata` in 16: write data.
- `rsp_valid` out 1: one-cycle pulse when a host frame completes.
- `rsp_rdata` out 16: read data; 0 after a write; held until the next response.

## Operation
States:
- HOLD: `phy_rst_n`=0; counts RST_CYCLES, then goes to WAIT.
- WAIT: `phy_rst_n`=1; counts WAIT_CYCLES, then goes to INIT.
- INIT: issues a write frame of INIT_DATA to INIT_REG; on frame end, sets `init_done`=1, loads the poll timer with POLL_CYCLES, and goes to IDLE.
- IDLE: `cmd_ready`=1.
  - A host handshake starts a host frame (HOST).
  - Otherwise, poll timer expiry starts a read of reg 1 (POLL).
  - If both occur in the same cycle, the host is served first and the poll runs right after.
- POLL: on frame end, `link_up` <= read bit 2; reloads the poll timer; goes to IDLE.
- HOST: on frame end, pulses `rsp_valid` and updates `rsp_rdata`; goes to IDLE. The poll timer keeps counting; an expiry during HOST is remembered and served next.

Frame format (64 bits, MSB first):
- 32 preamble ones;
- ST=01;
- OP=01 (write) or 10 (read);
- PHY_ADDR[4:0], REG[4:0];
- TA;
- DATA[15:0].

TA and drive rules:
- Write: TA=10, all 64 bits driven.
- Read: `mdio_oe`=0 from the first TA bit (bit index 17) through frame end; DATA is sampled from `mdio_i`.

Outputs outside frames: `mdio_oe`=0, `mdio_o`=1, `mdc`=0.

## Timing
Reset values (asserted asynchronously; state returns to HOLD):
- `phy_rst_n`=0, `mdc`=0, `mdio_o`=1, `mdio_oe`=0.
- `init_done`=0, `link_up`=0, `cmd_ready`=0, `rsp_valid`=0, `rsp_rdata`=0.
- A reset mid-frame aborts the frame immediately.

Phase timing:
- `phy_rst_n` rises exactly RST_CYCLES cycles after `rst_n` deasserts.
- The first frame starts WAIT_CYCLES later.

Bit timing:
- Frame start cycle: `mdio_oe`=1 and `mdio_o`=bit 63; `mdc` low.
- `mdc` toggles every MDC_DIV cycles. Each bit gets one full low phase then one high phase.
- The next bit is presented in the cycle `mdc` goes 1->0.
- Read data is sampled in the cycle `mdc` goes 0->1.
- The frame ends when bit 0's high phase ends: `mdc`=0 and `mdio_oe`=0 in that same cycle.
- Frame length is exactly 128*MDC_DIV cycles.

Handshake and response:
- `cmd_ready` is high only in IDLE. It drops the cycle after a handshake. The `cmd_*` fields are captured at the handshake.
- `rsp_valid` pulses in the cycle after frame end. The controller re-enters IDLE (`cmd_ready`=1) in the same cycle.
- Poll-timer reload value is counted from frame end.

## Test plan
- Reset release, MDC_DIV=2, RST_CYCLES=10, WAIT_CYCLES=20 -> `phy_rst_n` rises at cycle 10; first `mdio_oe` at cycle 30; init frame spans 256 cycles; `init_done`=1 after it.
- Init frame capture -> 32 ones, then 0101, 00000, 00000, 10, 16'h1140 on `mdio_o`; `cmd_ready` low throughout.
- Poll read, PHY model returns 16'h7869 -> `mdio_oe`=0 from TA onward; `link_up`=0 (bit 2=0). Model then returns 16'h786D -> `link_up`=1 after the next poll.
- Host read of reg 2 returning 16'h0022 -> OP=10, REG=00010; `rsp_valid` single pulse; `rsp_rdata`=16'h0022. Host write of reg 4, 16'h01E1 -> `rsp_rdata`=0.
- Host `cmd_valid` in the same cycle as poll expiry -> host frame first; poll frame starts the cycle after `rsp_valid`.
- `rst_n` asserted mid-frame (bit 40) -> outputs return to reset values in the same cycle; the full HOLD/WAIT/INIT sequence repeats after release.
